tvp_capture: RTL

TVP_CAPTURE -- requirements
Module: tvp_capture

---
 rtl/hp2vga_pkg.sv | 21 ++
 rtl/tvp_capture_if.sv | 30 +++
 rtl/tvp_edge_detect.sv | 36 +++
 rtl/tvp_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hp2vga_pkg.sv
// Shared definitions for the TVP video capture front end.
//   lock_state_t : encodings of the line-lock state machine
//   CNT_SAT      : saturation value of the 10-bit line/pixel counters
//   MATCH_LOCK   : number of consecutive good lines needed to lock
//   sat_inc()    : 10-bit increment that sticks at CNT_SAT
package hp2vga_pkg;

    typedef enum logic [1:0] {
        LK_UNLOCKED = 2'd0,
        LK_TRACK    = 2'd1,
        LK_LOCK     = 2'd2
    } lock_state_t;

    localparam logic [9:0] CNT_SAT    = 10'd1023;
    localparam logic [1:0] MATCH_LOCK = 2'd3;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_SAT) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/tvp_capture_if.sv
// Signal bundle between a TVP-style video source and the capture block.
//   hsync/vsync : active-low sync inputs, video : 10-bit pixel sample
//   pix_*       : captured pixel write port, line_len/locked/frame_start : status
// Handshake: there is no ready. pix_valid is a single-cycle write strobe;
// pix_x, pix_y and pix_data are meaningful only in a cycle where pix_valid
// is high, and the sink must accept every strobe (no backpressure exists).
interface tvp_capture_if;
    logic       hsync;
    logic       vsync;
    logic [9:0] video;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic [9:0] line_len;
    logic       locked;
    logic       frame_start;

    // Video source side (decoder model)
    modport master (
        output hsync, vsync, video,
        input  pix_x, pix_y, pix_data, pix_valid, line_len, locked, frame_start
    );

    // Capture side
    modport slave (
        input  hsync, vsync, video,
        output pix_x, pix_y, pix_data, pix_valid, line_len, locked, frame_start
    );
endinterface

// File: rtl/tvp_edge_detect.sv
// Two-stage input register with a single edge pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : raw input (a sync line, idle high)
//   pulse      : high for one cycle when stage1/stage2 show the selected edge
//                (RISE=1: stage2=0, stage1=1; RISE=0: stage2=1, stage1=0)
// Both stages reset to 1 so an idle-high sync line produces no edge at reset.
module tvp_edge_detect #(
    parameter logic RISE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign pulse = RISE ? (s1_q & ~s2_q) : (~s1_q & s2_q);

endmodule

// File: rtl/tvp_capture.sv
// Captures active video from a TVP-style decoder into a pixel write port.
//   TVP_CLK, RST_N          : pixel clock, asynchronous active-low reset
//   TVP_HSYNC, TVP_VSYNC    : active-low line / frame sync
//   TVP_VIDEO[9:0]          : pixel sample
//   PIX_X, PIX_Y, PIX_DATA  : active pixel coordinates and top 8 data bits
//   PIX_VALID               : write strobe for X/Y/DATA
//   LINE_LEN                : last measured line length in clocks
//   LOCKED                  : line timing stable (four identical lines seen)
//   FRAME_START             : one-clock pulse at the first line of a frame
// The line starts on the HSYNC rising edge. H_CNT is aligned with the second
// video stage, so the sample taken together with the first high HSYNC sample
// has H_CNT=0 and every output lands two clocks after the sampling edge.
module tvp_capture
    import hp2vga_pkg::*;
#(
    parameter int unsigned H_START  = 16,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_START  = 0,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned LINE_MIN = 64
) (
    input  logic       TVP_CLK,
    input  logic       RST_N,
    input  logic       TVP_HSYNC,
    input  logic       TVP_VSYNC,
    input  logic [9:0] TVP_VIDEO,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
    output logic [7:0] PIX_DATA,
    output logic       PIX_VALID,
    output logic [9:0] LINE_LEN,
    output logic       LOCKED,
    output logic       FRAME_START
);

    logic hs_rise;
    logic vs_fall;

    tvp_edge_detect #(.RISE(1'b1)) u_hs_edge (
        .clk   (TVP_CLK),
        .rst_n (RST_N),
        .d     (TVP_HSYNC),
        .pulse (hs_rise)
    );

    tvp_edge_detect #(.RISE(1'b0)) u_vs_edge (
        .clk   (TVP_CLK),
        .rst_n (RST_N),
        .d     (TVP_VSYNC),
        .pulse (vs_fall)
    );

    logic [9:0]  vid_s1_q, vid_s1_d;
    logic [9:0]  vid_s2_q, vid_s2_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        arm_q, arm_d;
    logic [9:0]  line_len_q, line_len_d;
    logic        frame_start_q, frame_start_d;
    lock_state_t state_q, state_d;
    logic [1:0]  match_q, match_d;
    logic        locked_q, locked_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [7:0]  pix_data_q, pix_data_d;

    logic [9:0]  new_len;
    logic        good_line;
    logic        frame_go;
    logic        in_h;
    logic        in_v;

    // Counters, line length and frame arming
    always_comb begin
        vid_s1_d = TVP_VIDEO;
        vid_s2_d = vid_s1_q;

        new_len    = h_cnt_q + 10'd1;
        h_cnt_d    = hs_rise ? 10'd0 : sat_inc(h_cnt_q);
        line_len_d = hs_rise ? new_len : line_len_q;

        // A VSYNC fall in the same cycle as the HSYNC rise counts as already
        // armed, so that very HSYNC edge begins the frame.
        frame_go      = hs_rise & (arm_q | vs_fall);
        arm_d         = (arm_q | vs_fall) & ~hs_rise;
        frame_start_d = frame_go;

        v_cnt_d = v_cnt_q;
        if (frame_go) begin
            v_cnt_d = 10'd0;
        end else if (hs_rise) begin
            v_cnt_d = sat_inc(v_cnt_q);
        end

        good_line = (new_len == line_len_q) && (32'(new_len) >= LINE_MIN);
    end

    // Lock state machine: next state and match count
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        case (state_q)
            LK_UNLOCKED: begin
                if (hs_rise && good_line) begin
                    state_d = LK_TRACK;
                    match_d = 2'd1;
                end
            end
            LK_TRACK: begin
                if (hs_rise) begin
                    if (good_line) begin
                        match_d = match_q + 2'd1;
                        if (match_q + 2'd1 == MATCH_LOCK) begin
                            state_d = LK_LOCK;
                        end
                    end else begin
                        state_d = LK_UNLOCKED;
                        match_d = 2'd0;
                    end
                end
            end
            LK_LOCK: begin
                // A saturated H_CNT means HSYNC has gone missing.
                if ((hs_rise && !good_line) || (h_cnt_q == CNT_SAT)) begin
                    state_d = LK_UNLOCKED;
                    match_d = 2'd0;
                end
            end
            default: begin
                state_d = LK_UNLOCKED;
                match_d = 2'd0;
            end
        endcase
        locked_d = (state_d == LK_LOCK);
    end

    // Pixel write port
    always_comb begin
        in_h = (32'(h_cnt_q) >= H_START) && (32'(h_cnt_q) < H_START + H_ACTIVE);
        in_v = (32'(v_cnt_q) >= V_START) && (32'(v_cnt_q) < V_START + V_ACTIVE);

        pix_valid_d = (state_q == LK_LOCK) && in_h && in_v;
        pix_x_d     = pix_valid_d ? (h_cnt_q - H_START[9:0]) : pix_x_q;
        pix_y_d     = pix_valid_d ? (v_cnt_q - V_START[9:0]) : pix_y_q;
        pix_data_d  = vid_s2_q[9:2];
    end

    always_ff @(posedge TVP_CLK or negedge RST_N) begin
        if (!RST_N) begin
            vid_s1_q      <= 10'd0;
            vid_s2_q      <= 10'd0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            arm_q         <= 1'b0;
            line_len_q    <= 10'd0;
            frame_start_q <= 1'b0;
            state_q       <= LK_UNLOCKED;
            match_q       <= 2'd0;
            locked_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_data_q    <= 8'd0;
        end else begin
            vid_s1_q      <= vid_s1_d;
            vid_s2_q      <= vid_s2_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            arm_q         <= arm_d;
            line_len_q    <= line_len_d;
            frame_start_q <= frame_start_d;
            state_q       <= state_d;
            match_q       <= match_d;
            locked_q      <= locked_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
        end
    end

    assign PIX_X       = pix_x_q;
    assign PIX_Y       = pix_y_q;
    assign PIX_DATA    = pix_data_q;
    assign PIX_VALID   = pix_valid_q;
    assign LINE_LEN    = line_len_q;
    assign LOCKED      = locked_q;
    assign FRAME_START = frame_start_q;

endmodule
